// File: rtl/feature_writer_if.sv
// Gather-side and memory-write-side bundle for feature_writer.
// master: the writer (drives request + write bus); slave: gather/memory side.
interface feature_writer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);

  localparam int ITEM_W = DATA_WIDTH / 4;

  // gather stage
  logic [ITEM_W-1:0]     i_gather_out;
  logic                  i_gather_valid;
  logic                  o_feature_writer_finish;

  // output memory
  logic                  o_wr_en;
  logic [ADDR_WIDTH-1:0] o_wr_addr;
  logic [DATA_WIDTH-1:0] o_wr_data;
  logic                  i_wr_ready;

  modport master (
    input  i_gather_out,
    input  i_gather_valid,
    output o_feature_writer_finish,
    output o_wr_en,
    output o_wr_addr,
    output o_wr_data,
    input  i_wr_ready
  );

  modport slave (
    output i_gather_out,
    output i_gather_valid,
    input  o_feature_writer_finish,
    input  o_wr_en,
    input  o_wr_addr,
    input  o_wr_data,
    output i_wr_ready
  );

endinterface

// File: rtl/feature_writer.sv
// Packs gathered items four per word and writes them to output memory.
// Ports: i_clk/i_rst_n, job control (i_start, i_num_items, i_base_addr),
// bus (gather + write handshake), status o_busy/o_done/o_overflow.
module feature_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [15:0]           i_num_items,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  feature_writer_if.master      bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow
);

  localparam int ITEM_W = DATA_WIDTH / 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    REQ       = 3'd2,
    WRITE     = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [15:0]           num_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [15:0]           cnt_q;
  logic [ADDR_WIDTH-1:0] word_q;
  logic [1:0]            lane_q;
  logic [DATA_WIDTH-1:0] pack_q;

  logic        start_acc;
  logic        job_go;
  logic        cap;
  logic [15:0] cnt_inc;
  logic        last_item;
  logic        wr_acc;
  logic        all_done;
  logic        stray;

  assign start_acc = (state_q == IDLE) && i_start;
  assign job_go    = start_acc && (i_num_items != 16'd0);
  assign cap       = (state_q == WAIT_DATA) && bus.i_gather_valid;
  assign cnt_inc   = cnt_q + 16'd1;
  assign last_item = (cnt_inc == num_q);
  assign wr_acc    = (state_q == WRITE) && bus.i_wr_ready;
  assign all_done  = (cnt_q == num_q);
  assign stray     = bus.i_gather_valid && (state_q != WAIT_DATA);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (job_go) begin
          state_d = WAIT_DATA;
        end else if (start_acc) begin
          state_d = DONE;
        end
      end
      WAIT_DATA: begin
        if (cap) begin
          if (lane_q == 2'd3 || last_item) begin
            state_d = WRITE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        state_d = WAIT_DATA;
      end
      WRITE: begin
        if (wr_acc) begin
          state_d = all_done ? DONE : REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address/data are gated by the write state so the bus idles at zero.
  always_comb begin
    bus.o_feature_writer_finish = 1'b0;
    bus.o_wr_en                 = 1'b0;
    bus.o_wr_addr               = '0;
    bus.o_wr_data               = '0;
    o_busy                      = 1'b0;
    o_done                      = 1'b0;
    unique case (state_q)
      IDLE: begin
      end
      WAIT_DATA: begin
        o_busy = 1'b1;
      end
      REQ: begin
        o_busy                      = 1'b1;
        bus.o_feature_writer_finish = 1'b1;
      end
      WRITE: begin
        o_busy        = 1'b1;
        bus.o_wr_en   = 1'b1;
        bus.o_wr_addr = base_q + word_q;
        bus.o_wr_data = pack_q;
      end
      DONE: begin
        o_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      num_q  <= '0;
      base_q <= '0;
      cnt_q  <= '0;
      word_q <= '0;
      lane_q <= '0;
      pack_q <= '0;
    end else begin
      if (job_go) begin
        num_q  <= i_num_items;
        base_q <= i_base_addr;
        cnt_q  <= '0;
        word_q <= '0;
        lane_q <= '0;
        pack_q <= '0;
      end else if (cap) begin
        pack_q[int'(lane_q)*ITEM_W +: ITEM_W] <= bus.i_gather_out;
        cnt_q <= cnt_inc;
        // The lane resets on write acceptance, so only bump it here
        // when the word is not yet full.
        if (!(lane_q == 2'd3 || last_item)) begin
          lane_q <= lane_q + 2'd1;
        end
      end else if (wr_acc) begin
        word_q <= word_q + 1'b1;
        pack_q <= '0;
        lane_q <= '0;
      end
    end
  end

  // Sticky: any item arriving outside WAIT_DATA is lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow <= 1'b0;
    end else if (start_acc) begin
      o_overflow <= 1'b0;
    end else if (stray) begin
      o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_feature_writer.sv
// Scoreboard bench for feature_writer.
module tb_feature_writer;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   num = '0;
  logic [AW-1:0] base = '0;
  logic          busy;
  logic          done;
  logic          ovf;

  feature_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  feature_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_num_items (num),
    .i_base_addr (base),
    .bus         (bus),
    .o_busy      (busy),
    .o_done      (done),
    .o_overflow  (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int req_cnt = 0;
  int done_cnt = 0;
  int wren_cnt = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] mon_e;

  // Writes are accepted at the next rising edge when wr_en && wr_ready.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_feature_writer_finish) req_cnt++;
      if (done) done_cnt++;
      if (bus.o_wr_en) wren_cnt++;
      if (bus.o_wr_en && bus.i_wr_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL write_unexpected got addr=%h data=%h want none",
                   bus.o_wr_addr, bus.o_wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          if ({bus.o_wr_addr, bus.o_wr_data} !== mon_e) begin
            bad++;
            $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                     bus.o_wr_addr, bus.o_wr_data,
                     mon_e[AW+DW-1:DW], mon_e[DW-1:0]);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] n, input logic [AW-1:0] b);
    start = 1'b1;
    num   = n;
    base  = b;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] item);
    bus.i_gather_valid = 1'b1;
    bus.i_gather_out   = item;
    step();
    bus.i_gather_valid = 1'b0;
  endtask

  // First item is sent unrequested; later ones wait for a request pulse.
  task automatic gather(input logic [7:0] items[$], input int first);
    for (int i = first; i < items.size(); i++) begin
      if (i > 0) begin
        bit got;
        got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
          @(negedge clk);
          got = bus.o_feature_writer_finish;
        end
        if (!got) begin
          total++;
          bad++;
          $display("FAIL req_timeout got none want request for item %0d", i);
          return;
        end
        step();
      end
      send(items[i]);
    end
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      got = done;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL done_timeout got no o_done want pulse");
    end
    step();
  endtask

  task automatic test_reset();
    int d0;
    #1;
    total++;
    if ({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data,
         bus.o_feature_writer_finish, busy, done, ovf} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got en=%b busy=%b done=%b ovf=%b want 0",
               bus.o_wr_en, busy, done, ovf);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    bus.i_wr_ready = 1'b0;
    start_job(16'd1, 10'h055);
    send(8'h99);
    @(negedge clk);
    total++;
    if (!(bus.o_wr_en === 1'b1 && bus.o_wr_addr === 10'h055 &&
          bus.o_wr_data === 32'h00000099 && busy === 1'b1)) begin
      bad++;
      $display("FAIL prereset_write got en=%b addr=%h data=%h want 1 055 00000099",
               bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data,
         bus.o_feature_writer_finish, busy, done, ovf} !== '0) begin
      bad++;
      $display("FAIL midjob_reset got en=%b addr=%h data=%h busy=%b want 0",
               bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, busy);
    end
    d0 = done_cnt;
    step();
    rst_n = 1'b1;
    bus.i_wr_ready = 1'b1;
    repeat (3) step();
    total++;
    if (!(busy === 1'b0 && bus.o_wr_en === 1'b0 && done_cnt == d0)) begin
      bad++;
      $display("FAIL post_reset_idle got busy=%b en=%b dones=%0d want 0 0 0",
               busy, bus.o_wr_en, done_cnt - d0);
    end
  endtask

  task automatic test_full_word();
    int r0;
    int d0;
    logic [7:0] q[$];
    r0 = req_cnt;
    d0 = done_cnt;
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_q.push_back({10'h010, 32'h44332211});
    start_job(16'd4, 10'h010);
    gather(q, 0);
    wait_done();
    repeat (2) step();
    total++;
    if (req_cnt - r0 != 3) begin
      bad++;
      $display("FAIL full_reqs got %0d want 3", req_cnt - r0);
    end
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL full_done got %0d want 1", done_cnt - d0);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL full_pending got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_partial_wrap();
    int r0;
    logic [7:0] q[$];
    r0 = req_cnt;
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    exp_q.push_back({10'h3FF, 32'h44332211});
    exp_q.push_back({10'h000, 32'h00006655});
    start_job(16'd6, 10'h3FF);
    gather(q, 0);
    wait_done();
    repeat (2) step();
    total++;
    if (req_cnt - r0 != 5) begin
      bad++;
      $display("FAIL wrap_reqs got %0d want 5", req_cnt - r0);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL wrap_pending got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int r0;
    logic [7:0] q[$];
    r0 = req_cnt;
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    exp_q.push_back({10'h100, 32'h04030201});
    exp_q.push_back({10'h101, 32'h00000005});
    bus.i_wr_ready = 1'b0;
    start_job(16'd5, 10'h100);
    fork
      gather(q, 0);
      begin
        bit got;
        logic [AW-1:0] a;
        logic [DW-1:0] dt;
        got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
          @(negedge clk);
          got = bus.o_wr_en;
        end
        a  = bus.o_wr_addr;
        dt = bus.o_wr_data;
        total++;
        if (!got || a !== 10'h100 || dt !== 32'h04030201) begin
          bad++;
          $display("FAIL bp_first got en=%b addr=%h data=%h want 1 100 04030201",
                   got, a, dt);
        end
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          total++;
          if (!(bus.o_wr_en === 1'b1 && bus.o_wr_addr === a &&
                bus.o_wr_data === dt && bus.o_feature_writer_finish === 1'b0)) begin
            bad++;
            $display("FAIL bp_hold got en=%b addr=%h data=%h req=%b want 1 %h %h 0",
                     bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data,
                     bus.o_feature_writer_finish, a, dt);
          end
        end
        @(posedge clk);
        #1 bus.i_wr_ready = 1'b1;
        @(negedge clk);
        total++;
        if (!(bus.o_wr_en === 1'b1 && bus.o_feature_writer_finish === 1'b0)) begin
          bad++;
          $display("FAIL bp_accept got en=%b req=%b want 1 0",
                   bus.o_wr_en, bus.o_feature_writer_finish);
        end
        @(negedge clk);
        total++;
        if (bus.o_feature_writer_finish !== 1'b1) begin
          bad++;
          $display("FAIL bp_req_after got %b want 1",
                   bus.o_feature_writer_finish);
        end
      end
    join
    wait_done();
    repeat (2) step();
    total++;
    if (req_cnt - r0 != 4 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_totals got reqs=%0d pending=%0d want 4 0",
               req_cnt - r0, exp_q.size());
    end
  endtask

  task automatic test_empty();
    int r0;
    int w0;
    int d0;
    r0 = req_cnt;
    w0 = wren_cnt;
    d0 = done_cnt;
    start_job(16'd0, 10'h200);
    @(negedge clk);
    total++;
    if (!(done === 1'b1 && busy === 1'b0)) begin
      bad++;
      $display("FAIL empty_done got done=%b busy=%b want 1 0", done, busy);
    end
    step();
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL empty_done_once got %b want 0", done);
    end
    step();
    total++;
    if (req_cnt != r0 || wren_cnt != w0 || done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL empty_quiet got reqs=%0d wren=%0d dones=%0d want 0 0 1",
               req_cnt - r0, wren_cnt - w0, done_cnt - d0);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] q[$];
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_q.push_back({10'h020, 32'h44332211});
    start_job(16'd4, 10'h020);
    send(8'h11);
    bus.i_gather_valid = 1'b1;
    bus.i_gather_out   = 8'hEE;
    step();
    bus.i_gather_valid = 1'b0;
    @(negedge clk);
    total++;
    if (ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set got %b want 1", ovf);
    end
    step();
    send(8'h22);
    gather(q, 2);
    wait_done();
    step();
    total++;
    if (ovf !== 1'b1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL ovf_sticky got ovf=%b pending=%0d want 1 0",
               ovf, exp_q.size());
    end
    exp_q.push_back({10'h030, 32'h00000077});
    start_job(16'd1, 10'h030);
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear got %b want 0", ovf);
    end
    send(8'h77);
    wait_done();
    step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL ovf_next_job got pending=%0d want 0", exp_q.size());
    end
  endtask

  initial begin
    bus.i_gather_valid = 1'b0;
    bus.i_gather_out   = '0;
    bus.i_wr_ready     = 1'b1;
    test_reset();
    test_full_word();
    test_partial_wrap();
    test_backpressure();
    test_empty();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/feature_writer.md
FEATURE_WRITER -- requirements
Module: feature_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: packed output word width; one item is DATA_WIDTH/4 bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: output memory word-address width.
REQ-003 SHALL have port i_clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_start  input  1  job start pulse.
REQ-006 SHALL have port i_num_items  input  16  number of items in the job.
REQ-007 SHALL have port i_base_addr  input  ADDR_WIDTH  first output word address.
REQ-008 SHALL have port i_gather_out  input  DATA_WIDTH/4  item data from the gather stage.
REQ-009 SHALL have port i_gather_valid  input  1  item valid, one-cycle pulse per item.
REQ-010 SHALL have port o_feature_writer_finish  output  1  next-item request pulse to the gather stage.
REQ-011 SHALL have port o_wr_en  output  1  output memory write request.
REQ-012 SHALL have port o_wr_addr  output  ADDR_WIDTH  write word address.
REQ-013 SHALL have port o_wr_data  output  DATA_WIDTH  packed write word.
REQ-014 SHALL have port i_wr_ready  input  1  memory accepts the write in this cycle.
REQ-015 SHALL have ports o_busy, o_done and o_overflow, each output 1: job active; job-complete pulse; sticky unexpected-valid flag.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, WAIT_DATA, REQ, WRITE and DONE; all outputs decode from registers.
REQ-017 IDLE: on i_start with i_num_items!=0, SHALL latch num_items and base_addr, clear the item count, word index, lane index, pack register and o_overflow, then go to WAIT_DATA.
REQ-018 IDLE: on i_start with i_num_items==0, SHALL go to DONE with no writes and no requests.
REQ-019 SHALL ignore i_start in every state other than IDLE.
REQ-020 WAIT_DATA: on i_gather_valid, SHALL write i_gather_out into pack lane L, bits [L*DATA_WIDTH/4 +: DATA_WIDTH/4], and increment the item count.
REQ-021 After a capture, SHALL go to WRITE if L==3 or the item was the last one; otherwise SHALL increment L and go to REQ.
REQ-022 REQ: SHALL assert o_feature_writer_finish for exactly one cycle, then go to WAIT_DATA; an item captured at cycle t therefore gives the request at cycle t+1.
REQ-023 WRITE: SHALL assert o_wr_en with o_wr_addr = base_addr + word_index (mod 2^ADDR_WIDTH) and o_wr_data = pack register.
REQ-024 WRITE: SHALL hold o_wr_en, o_wr_addr and o_wr_data stable until i_wr_ready=1.
REQ-025 On WRITE acceptance, SHALL increment word_index, zero the pack register and set L=0; it SHALL go to DONE if all items are captured, otherwise to REQ.
REQ-026 Unfilled lanes of a final partial word SHALL be zero.
REQ-027 No request pulse SHALL be issued while a write is pending; the number of request pulses per job SHALL be num_items-1, because the gather stage sends the first item unrequested.
REQ-028 DONE: SHALL assert o_done for one cycle, then go to IDLE.
REQ-029 o_busy SHALL be 1 in WAIT_DATA, REQ and WRITE, and 0 otherwise.
REQ-030 i_gather_valid in any state other than WAIT_DATA SHALL set o_overflow and discard the data; o_overflow SHALL clear only on an accepted i_start or on reset.
REQ-031 The item count SHALL be 16 bits wide and word_index ADDR_WIDTH bits wide, with word_index wrapping modulo 2^ADDR_WIDTH.

Reset
REQ-032 While i_rst_n=0, SHALL immediately force state IDLE, all counters and the pack register to 0, and every output to 0.
REQ-033 Reset asserted mid-job SHALL abandon the job with no o_done; the next job SHALL require a new i_start.

Verification
REQ-034 Reset check: assert reset at any state -> all outputs 0 in the same cycle; FSM in IDLE after release.
REQ-035 Single full word: num_items=4, base=0x010, items 0x11,0x22,0x33,0x44, wr_ready=1 -> 3 request pulses; one write at addr 0x010 with data 0x44332211; o_done pulses once.
REQ-036 Partial word with wrap: num_items=6, base=0x3FF -> writes 0x44332211 at 0x3FF and 0x00006655 at 0x000; 5 request pulses.
REQ-037 Backpressure: wr_ready low for 5 cycles during WRITE -> o_wr_en, addr and data stable, no request pulse; the first request comes the cycle after acceptance.
REQ-038 Empty job: i_start with num_items=0 -> o_done the next cycle; o_wr_en and o_feature_writer_finish never asserted.
REQ-039 Overflow: i_gather_valid pulsed in REQ or WRITE -> o_overflow=1 and stays set; data not packed; o_overflow clears on the next accepted i_start.
